// File: rtl/modinv_for_2503.sv
// Sequential Fermat inverter over GF(2503): dout_r = din_a^2501 mod 2503.
// One shared multiplier feeds one Barrett reducer; square-and-multiply runs in constant time.
module modinv_for_2503 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] din_a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] dout_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_zero
);

    localparam logic [11:0] MODULUS  = 12'd2503;
    localparam logic [11:0] EXPONENT = 12'd2501;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Barrett reduction of a product below 2503^2; the quotient estimate is short by at most 2.
    function automatic logic [11:0] red(input logic [22:0] x);
        logic [23:0] q_mu;
        logic [11:0] t;
        logic [12:0] r;
        q_mu = {13'd0, x[22:12]} * 24'd6702;
        t    = 12'(q_mu >> 24'd12);
        r    = x[12:0] - ({1'b0, t} * 13'd2503);
        if (r >= 13'd2503) begin
            r = r - 13'd2503;
        end else begin
            r = r;
        end
        if (r >= 13'd2503) begin
            r = r - 13'd2503;
        end else begin
            r = r;
        end
        return r[11:0];
    endfunction

    state_t      state_r;
    logic [11:0] acc_r;
    logic [11:0] base_r;
    logic [3:0]  idx_r;

    logic [11:0] op_b_s;
    logic [22:0] prod_s;
    logic [11:0] red_s;
    logic [11:0] mul_next_s;
    logic [11:0] base_in_s;

    // Shared datapath: squaring uses acc twice, multiplying uses acc and base.
    always_comb begin
        op_b_s = base_r;
        if (state_r == SQR) begin
            op_b_s = acc_r;
        end else begin
            op_b_s = base_r;
        end
        prod_s = {11'd0, acc_r} * {11'd0, op_b_s};
        red_s  = red(prod_s);
        mul_next_s = acc_r;
        if (EXPONENT[idx_r]) begin
            mul_next_s = red_s;
        end else begin
            mul_next_s = acc_r;
        end
        base_in_s = din_a;
        if (din_a >= MODULUS) begin
            base_in_s = din_a - MODULUS;
        end else begin
            base_in_s = din_a;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
            dout_r    <= 12'd0;
            acc_r     <= 12'd1;
            idx_r     <= 4'd11;
            base_r    <= 12'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        base_r   <= base_in_s;
                        acc_r    <= 12'd1;
                        idx_r    <= 4'd11;
                        in_ready <= 1'b0;
                        state_r  <= SQR;
                    end
                end
                SQR: begin
                    acc_r   <= red_s;
                    state_r <= MUL;
                end
                MUL: begin
                    acc_r <= mul_next_s;
                    if (idx_r == 4'd0) begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        dout_r    <= mul_next_s;
                        out_zero  <= (base_r == 12'd0);
                    end else begin
                        idx_r   <= idx_r - 4'd1;
                        state_r <= SQR;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_for_2503.sv
// Bench for modinv_for_2503: vector table, full 1..2502 inverse sweep, and handshake corner cases.
module tb_modinv_for_2503;

    logic        clk;
    logic        rst_n;
    logic [11:0] din_a;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] dout_r;
    logic        out_valid;
    logic        out_ready;
    logic        out_zero;

    modinv_for_2503 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_a     (din_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout_r    (dout_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [11:0] din;
        logic [11:0] dout;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [11:0] din;
        logic [11:0] dout;
        logic        zero;
        bit          prop;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [11:0] a, input logic [11:0] e, input logic ez, input bit prop);
        sb_t s;
        s.din  = a;
        s.dout = e;
        s.zero = ez;
        s.prop = prop;
        sb_q.push_back(s);
    endtask

    // Scoreboard: a result is consumed on the edge following a negedge with valid and ready high.
    sb_t sb_e;
    int  prod_chk;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                if (sb_e.prop) begin
                    prod_chk = ((int'(sb_e.din) % 2503) * int'(dout_r)) % 2503;
                    check("inverse_property", prod_chk, 1);
                    check("sweep_zero", int'(out_zero), 0);
                end else begin
                    check("dout", int'(dout_r), int'(sb_e.dout));
                    check("out_zero", int'(out_zero), int'(sb_e.zero));
                end
            end
        end
    end

    // One full transaction with out_ready high; also checks latency and in_ready while busy.
    task automatic run_op(input logic [11:0] a, input logic [11:0] e, input logic ez, input bit prop);
        int lat;
        bit busy_ok;
        for (int w = 0; w < 40 && !in_ready; w++) tick();
        check("in_ready_before_accept", int'(in_ready), 1);
        din_a    = a;
        in_valid = 1'b1;
        tick();
        push_exp(a, e, ez, prop);
        in_valid = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 60) begin
            if (in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        check("latency", lat, 24);
        check("in_ready_low_busy", int'(busy_ok), 1);
        tick();
        check("out_valid_after_hs", int'(out_valid), 0);
        check("in_ready_after_hs", int'(in_ready), 1);
    endtask

    vec_t vecs[8];

    initial begin
        int          lat;
        bit          seen;
        int          na;
        int          no;
        bit          prev_ov;
        bit          acc_now;
        int          acc_cyc[3];
        int          out_cyc[3];
        logic [11:0] ops[3];
        logic [11:0] exps[3];

        vecs[0] = '{din: 12'd2,    dout: 12'd1252, zero: 1'b0};
        vecs[1] = '{din: 12'd1,    dout: 12'd1,    zero: 1'b0};
        vecs[2] = '{din: 12'd3,    dout: 12'd1669, zero: 1'b0};
        vecs[3] = '{din: 12'd2502, dout: 12'd2502, zero: 1'b0};
        vecs[4] = '{din: 12'd2505, dout: 12'd1252, zero: 1'b0};
        vecs[5] = '{din: 12'd0,    dout: 12'd0,    zero: 1'b1};
        vecs[6] = '{din: 12'd2503, dout: 12'd0,    zero: 1'b1};
        vecs[7] = '{din: 12'd4,    dout: 12'd626,  zero: 1'b0};

        rst_n     = 1'b0;
        din_a     = 12'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_zero", int'(out_zero), 0);
        check("rst_dout", int'(dout_r), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].din, vecs[i].dout, vecs[i].zero, 1'b0);
        end

        for (int a = 1; a <= 2502; a++) begin
            run_op(12'(a), 12'd0, 1'b0, 1'b1);
        end

        // Back-pressure: result held while out_ready is low, stray in_valid ignored.
        out_ready = 1'b0;
        din_a     = 12'd3;
        in_valid  = 1'b1;
        tick();
        push_exp(12'd3, 12'd1669, 1'b0, 1'b0);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 24);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_dout", int'(dout_r), 1669);
            check("bp_out_zero", int'(out_zero), 0);
            check("bp_in_ready", int'(in_ready), 0);
            if (i == 3) begin
                din_a    = 12'd5;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);

        // Reset at compute cycle 10 aborts the operation.
        din_a    = 12'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", int'(seen), 0);
        run_op(12'd3, 12'd1669, 1'b0, 1'b0);

        // Back-to-back with in_valid held high.
        ops[0]  = 12'd2;    ops[1]  = 12'd3;    ops[2]  = 12'd4;
        exps[0] = 12'd1252; exps[1] = 12'd1669; exps[2] = 12'd626;
        din_a    = ops[0];
        in_valid = 1'b1;
        na       = 0;
        no       = 0;
        prev_ov  = out_valid;
        for (int cyc = 1; cyc <= 150 && no < 3; cyc++) begin
            acc_now = in_ready && in_valid;
            tick();
            if (acc_now) begin
                push_exp(ops[na], exps[na], 1'b0, 1'b0);
                acc_cyc[na] = cyc;
                na++;
                if (na < 3) din_a = ops[na];
                else in_valid = 1'b0;
            end
            if (out_valid && !prev_ov) begin
                out_cyc[no] = cyc;
                no++;
            end
            prev_ov = out_valid;
        end
        in_valid = 1'b0;
        check("b2b_accepts", na, 3);
        check("b2b_results", no, 3);
        if (na == 3 && no == 3) begin
            check("b2b_accept_gap1", acc_cyc[1] - acc_cyc[0], 26);
            check("b2b_accept_gap2", acc_cyc[2] - acc_cyc[1], 26);
            check("b2b_out_gap1", out_cyc[1] - out_cyc[0], 26);
            check("b2b_out_gap2", out_cyc[2] - out_cyc[1], 26);
            check("b2b_first_latency", out_cyc[0] - acc_cyc[0], 24);
        end
        tick();
        tick();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
